// File: rtl/kf_seq_ctrl_pkg.sv
// Shared definitions for the Kalman-step sequencer: state encoding,
// err_stage codes, default watchdog limit and a wait-state helper.
package kf_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRED = 3'd1,
    S_KG   = 3'd2,
    S_UPD  = 3'd3,
    S_OUT  = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_PRED = 2'd1;
  localparam logic [1:0] ERR_KG   = 2'd2;
  localparam logic [1:0] ERR_UPD  = 2'd3;

  localparam int unsigned TMO_LIM_DEF = 40;

  // True in the three states that wait on a stage done pulse.
  function automatic logic is_wait(input state_t s);
    return (s == S_PRED) || (s == S_KG) || (s == S_UPD);
  endfunction

endpackage

// File: rtl/kf_stage_wdog.sv
// Stage watchdog shared by all wait states.
// Ports: clk, rst_n; clr (zero the count), en (count this cycle);
//        expired (count has reached TMO_LIM, decoded from the register).
module kf_stage_wdog #(
  parameter int unsigned TMO_W   = 6,
  parameter int unsigned TMO_LIM = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TMO_W-1:0] cnt;

  // Counter holds at the limit so a stalled exit cannot wrap it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  assign expired = (cnt == TMO_W'(TMO_LIM));

endmodule

// File: rtl/kf_seq_ctrl.sv
// Iteration sequencer for one Kalman filter step: accept a measurement,
// run predict -> gain -> update with per-stage watchdog, then hand the
// estimate downstream.
// Ports: clk, rst_n; meas_valid/meas_ready/meas_latch (measurement intake);
//        pred_/kg_/upd_ start (out) and done (in) per stage;
//        out_valid/out_ready (result handshake); busy; clr_err, err,
//        err_stage (sticky watchdog error); iter_cnt (completed iterations).
// Optional: define KF_SEQ_PERF_EN to add lat_cycles[15:0], the
//           accept-to-out_valid latency of the last completed iteration.
module kf_seq_ctrl
  import kf_seq_ctrl_pkg::*;
#(
  parameter int unsigned TMO_W   = 6,
  parameter int unsigned TMO_LIM = TMO_LIM_DEF,
  parameter int unsigned ITER_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              meas_valid,
  output logic              meas_ready,
  output logic              meas_latch,
  output logic              pred_start,
  input  logic              pred_done,
  output logic              kg_start,
  input  logic              kg_done,
  output logic              upd_start,
  input  logic              upd_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  input  logic              clr_err,
  output logic              err,
  output logic [1:0]        err_stage,
  output logic [ITER_W-1:0] iter_cnt
`ifdef KF_SEQ_PERF_EN
  ,
  output logic [15:0]       lat_cycles
`endif
);

  state_t state;
  logic   stage_done_c;
  logic   wait_c;
  logic   wd_expired;

  // Intake handshake is decoded straight from the state register.
  assign meas_ready = (state == S_IDLE);
  assign meas_latch = meas_ready & meas_valid;
  assign busy       = (state != S_IDLE);
  assign wait_c     = is_wait(state);

  // Only the done pulse belonging to the current stage counts.
  always_comb begin
    stage_done_c = 1'b0;
    case (state)
      S_PRED:  stage_done_c = pred_done;
      S_KG:    stage_done_c = kg_done;
      S_UPD:   stage_done_c = upd_done;
      default: stage_done_c = 1'b0;
    endcase
  end

  // Cleared outside wait states and on a stage exit, so every stage
  // entry starts counting from zero.
  kf_stage_wdog #(
    .TMO_W   (TMO_W),
    .TMO_LIM (TMO_LIM)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!wait_c || stage_done_c),
    .en      (wait_c),
    .expired (wd_expired)
  );

  // Sequencer state and registered outputs; done beats the watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pred_start <= 1'b0;
      kg_start   <= 1'b0;
      upd_start  <= 1'b0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
      err_stage  <= ERR_NONE;
      iter_cnt   <= '0;
    end else begin
      pred_start <= 1'b0;
      kg_start   <= 1'b0;
      upd_start  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (meas_latch) begin
            state      <= S_PRED;
            pred_start <= 1'b1;
          end
        end
        S_PRED: begin
          if (pred_done) begin
            state    <= S_KG;
            kg_start <= 1'b1;
          end else if (wd_expired) begin
            state     <= S_ERR;
            err       <= 1'b1;
            err_stage <= ERR_PRED;
          end
        end
        S_KG: begin
          if (kg_done) begin
            state     <= S_UPD;
            upd_start <= 1'b1;
          end else if (wd_expired) begin
            state     <= S_ERR;
            err       <= 1'b1;
            err_stage <= ERR_KG;
          end
        end
        S_UPD: begin
          if (upd_done) begin
            state     <= S_OUT;
            out_valid <= 1'b1;
          end else if (wd_expired) begin
            state     <= S_ERR;
            err       <= 1'b1;
            err_stage <= ERR_UPD;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            iter_cnt  <= iter_cnt + ITER_W'(1);
          end
        end
        S_ERR: begin
          if (clr_err) begin
            state     <= S_IDLE;
            err       <= 1'b0;
            err_stage <= ERR_NONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef KF_SEQ_PERF_EN
  logic [15:0] lat_cnt;

  // lat_cnt equals cycles since accept; loaded (+1) on the cycle that
  // moves into OUT so lat_cycles is valid together with out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt    <= '0;
      lat_cycles <= '0;
    end else begin
      if (meas_latch) begin
        lat_cnt <= 16'd1;
      end else if (wait_c && (lat_cnt != 16'hFFFF)) begin
        lat_cnt <= lat_cnt + 16'd1;
      end
      if ((state == S_UPD) && upd_done) begin
        lat_cycles <= (lat_cnt == 16'hFFFF) ? lat_cnt : lat_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_kf_seq_ctrl.sv
// Randomized scoreboard bench for kf_seq_ctrl. The driver predicts the
// cycle of every accept, start pulse, out_valid rise and err rise from the
// stage delays it chooses; the monitor pops and compares on each event.
module tb_kf_seq_ctrl;

  localparam int TMO_LIM = 40;
  localparam int ITER_W  = 2;
  localparam int ITER_M  = 4;

  localparam int EV_ACC = 0, EV_PRED = 1, EV_KG = 2, EV_UPD = 3, EV_OUT = 4, EV_ERR = 5;
  localparam int M_NORM = 0, M_NOM = 1, M_HP = 2, M_HK = 3, M_HU = 4,
                 M_RACE = 5, M_LATE = 6, M_RST = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic meas_valid = 1'b0, meas_ready, meas_latch;
  logic pred_start, kg_start, upd_start;
  logic pred_done = 1'b0, kg_done = 1'b0, upd_done = 1'b0;
  logic out_valid, out_ready = 1'b0, busy, clr_err = 1'b0, err;
  logic [1:0] err_stage;
  logic [ITER_W-1:0] iter_cnt;
`ifdef KF_SEQ_PERF_EN
  logic [15:0] lat_cycles;
`endif

  kf_seq_ctrl #(.TMO_W(6), .TMO_LIM(TMO_LIM), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .meas_valid(meas_valid), .meas_ready(meas_ready), .meas_latch(meas_latch),
    .pred_start(pred_start), .pred_done(pred_done),
    .kg_start(kg_start), .kg_done(kg_done),
    .upd_start(upd_start), .upd_done(upd_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .clr_err(clr_err), .err(err), .err_stage(err_stage),
    .iter_cnt(iter_cnt)
`ifdef KF_SEQ_PERF_EN
    , .lat_cycles(lat_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0, bad = 0;
  int iter_m = 0, lat_m = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int kind; int cyc; int val; } ev_t;
  ev_t sb[$];

  task automatic push(input int k, input int c, input int v);
    ev_t e;
    e.kind = k; e.cyc = c; e.val = v;
    sb.push_back(e);
  endtask

  task automatic observe(input int k, input int v);
    ev_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind %0d val %0d at cycle %0d, required none", k, v, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.cyc != cyc || e.val != v) begin
        bad++;
        $display("FAIL event: got kind %0d cycle %0d val %0d required kind %0d cycle %0d val %0d",
                 k, cyc, v, e.kind, e.cyc, e.val);
      end
    end
  endtask

  // Monitor: every observable event is matched against the scoreboard.
  logic prev_ov = 1'b0, prev_err = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov  = 1'b0;
      prev_err = 1'b0;
    end else begin
      if (meas_latch) observe(EV_ACC, 0);
      if (pred_start) observe(EV_PRED, 0);
      if (kg_start) observe(EV_KG, 0);
      if (upd_start) observe(EV_UPD, 0);
      if (out_valid && !prev_ov) observe(EV_OUT, 0);
      if (err && !prev_err) observe(EV_ERR, int'(err_stage));
      prev_ov  = out_valid;
      prev_err = err;
    end
  end

  // Stage stubs: done arrives d cycles after start (d=0: same cycle,
  // d<0: never). Stray done pulses only when that stage is not pending.
  int cur_dp = 0, cur_dk = 0, cur_du = 0;
  int p_left = -1, k_left = -1, u_left = -1;
  bit stray_en = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      p_left = -1; k_left = -1; u_left = -1;
      pred_done = 1'b0; kg_done = 1'b0; upd_done = 1'b0;
    end else begin
      pred_done = 1'b0; kg_done = 1'b0; upd_done = 1'b0;
      if (pred_start) p_left = cur_dp;
      if (kg_start) k_left = cur_dk;
      if (upd_start) u_left = cur_du;
      if (p_left == 0) pred_done = 1'b1;
      if (k_left == 0) kg_done = 1'b1;
      if (u_left == 0) upd_done = 1'b1;
      if (p_left >= 0) p_left--;
      if (k_left >= 0) k_left--;
      if (u_left >= 0) u_left--;
      if (stray_en) begin
        if (p_left < 0 && !pred_done && $urandom_range(0, 7) == 0) pred_done = 1'b1;
        if (k_left < 0 && !kg_done && $urandom_range(0, 7) == 0) kg_done = 1'b1;
        if (u_left < 0 && !upd_done && $urandom_range(0, 7) == 0) upd_done = 1'b1;
      end
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_meas_ready"}, int'(meas_ready), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_starts"}, int'({pred_start, kg_start, upd_start}), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_err_stage"}, int'(err_stage), 0);
    chk({tag, "_iter_cnt"}, int'(iter_cnt), iter_m);
`ifdef KF_SEQ_PERF_EN
    chk({tag, "_lat_cycles"}, int'(lat_cycles), lat_m);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    meas_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    p_left = -1; k_left = -1; u_left = -1;
    pred_done = 1'b0; kg_done = 1'b0; upd_done = 1'b0;
    sb.delete();
    iter_m = 0; lat_m = 0;
    #1;
    check_idle_outputs("reset");
    adv();
    rst_n = 1'b1;
  endtask

  task automatic run_iter(input int mode);
    int dp, dk, du, bp, t, p, k, u, last, exp_stage, nhold;
    bit hold, got, hang;
    dp = $urandom_range(0, 4);
    dk = ($urandom_range(0, 1) == 1) ? 17 : $urandom_range(0, 20);
    du = $urandom_range(0, 4);
    bp = $urandom_range(0, 5);
    hold = 1'($urandom_range(0, 1));
    exp_stage = 0; k = 0; u = 0;
    case (mode)
      M_NOM:  begin dp = 2; dk = 17; du = 3; bp = 0; end
      M_HP:   dp = -1;
      M_HK:   dk = -1;
      M_HU:   du = -1;
      M_RACE: du = TMO_LIM;
      M_LATE: du = TMO_LIM + 1;
      M_RST:  dk = 30;
      default: ;
    endcase
    hang = (mode == M_HP || mode == M_HK || mode == M_HU || mode == M_LATE);
    stray_en = (mode == M_NORM || mode == M_NOM || mode == M_RACE);
    cur_dp = dp; cur_dk = dk; cur_du = du;

    repeat ($urandom_range(0, 2)) adv();
    chk("idle_ready", int'(meas_ready), 1);
    out_ready = (bp == 0 && !hang && mode != M_RST);
    meas_valid = 1'b1;
    t = cyc;

    push(EV_ACC, t, 0);
    p = t + 1;
    push(EV_PRED, p, 0);
    if (mode == M_HP) begin
      last = p + TMO_LIM + 1; exp_stage = 1; push(EV_ERR, last, 1);
    end else begin
      k = p + dp + 1;
      push(EV_KG, k, 0);
      if (mode == M_HK) begin
        last = k + TMO_LIM + 1; exp_stage = 2; push(EV_ERR, last, 2);
      end else if (mode == M_RST) begin
        last = k;
      end else begin
        u = k + dk + 1;
        push(EV_UPD, u, 0);
        if (mode == M_HU || mode == M_LATE) begin
          last = u + TMO_LIM + 1; exp_stage = 3; push(EV_ERR, last, 3);
        end else begin
          last = u + du + 1; push(EV_OUT, last, 0);
        end
      end
    end

    got = 1'b0;
    for (int i = 0; i < last - t + 10; i++) begin
      adv();
      if (!hold || cyc >= last) meas_valid = 1'b0;
      if (sb.size() == 0) begin
        got = 1'b1;
        break;
      end
    end
    meas_valid = 1'b0;
    if (!got) begin
      chk("event_timeout", 0, 1);
      do_reset();
      return;
    end

    if (mode == M_RST) begin
      repeat (3) adv();
      do_reset();
    end else if (hang) begin
      nhold = $urandom_range(1, 3);
      for (int j = 0; j < nhold; j++) begin
        chk("err_flag", int'(err), 1);
        chk("err_stage", int'(err_stage), exp_stage);
        chk("err_busy", int'(busy), 1);
        chk("err_meas_ready", int'(meas_ready), 0);
        adv();
      end
      clr_err = 1'b1;
      adv();
      clr_err = 1'b0;
      check_idle_outputs("after_clr");
    end else begin
      for (int j = 0; j < bp; j++) begin
        chk("bp_out_valid", int'(out_valid), 1);
        chk("bp_meas_ready", int'(meas_ready), 0);
        chk("bp_iter_cnt", int'(iter_cnt), iter_m);
        if (j == bp - 1) out_ready = 1'b1;
        else clr_err = 1'($urandom_range(0, 1));
        adv();
        clr_err = 1'b0;
      end
      out_ready = 1'b0;
      iter_m = (iter_m + 1) % ITER_M;
      lat_m = last - t;
      check_idle_outputs("done");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("por");
    rst_n = 1'b1;
    for (int it = 0; it < 30; it++) begin
      int r, mode;
      case (it)
        0: mode = M_NOM;
        1: mode = M_HK;
        2: mode = M_RACE;
        3: mode = M_LATE;
        4: mode = M_HP;
        5: mode = M_RST;
        6: mode = M_NOM;
        7: mode = M_HU;
        default: begin
          r = $urandom_range(0, 9);
          mode = (r == 0) ? M_HP : (r == 1) ? M_HK : (r == 2) ? M_HU :
                 (r == 3) ? M_RACE : M_NORM;
        end
      endcase
      run_iter(mode);
    end
    repeat (3) adv();
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
